// File: rtl/core_pkg.sv
// Shared types for the memory port arbiter: FSM state encoding and
// transaction owner encoding.
package core_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/arb_wait_timer.sv
// Saturating wait-state counter; o_expired flags that MAX wait cycles have elapsed.
module arb_wait_timer #(
    parameter int MAX = 255
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int CW = $clog2(MAX + 1);
    localparam logic [CW-1:0] LIM = CW'(MAX);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != LIM)) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_expired = (r_cnt == LIM);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store.
// Data wins arbitration up to FAIR_MAX consecutive grants while fetch waits.
module mem_port_arbiter
    import core_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int FAIR_MAX = 4,
    parameter int TIMEOUT  = 255
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic              o_if_ack,
    output logic [DATA_W-1:0] o_if_rdata,
    output logic              o_if_err,
    input  logic              i_d_req,
    input  logic              i_d_we,
    input  logic [ADDR_W-1:0] i_d_addr,
    input  logic [DATA_W-1:0] i_d_wdata,
    output logic              o_d_ack,
    output logic [DATA_W-1:0] o_d_rdata,
    output logic              o_d_err,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic              i_mem_ready,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    localparam int FW = $clog2(FAIR_MAX + 1);
    localparam logic [FW-1:0] FAIR_LIM = FW'(FAIR_MAX);

    arb_state_t    r_state, w_next;
    logic          r_owner;
    logic [FW-1:0] r_fair;
    logic          w_grant_d, w_grant_i, w_done, w_tmo, w_expired;

    arb_wait_timer #(.MAX(TIMEOUT)) u_timer (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clr     (w_grant_d | w_grant_i),
        .i_en      ((r_state == BUSY) && !i_mem_ready),
        .o_expired (w_expired)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_grant_d = 1'b0;
        w_grant_i = 1'b0;
        w_done    = 1'b0;
        w_tmo     = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_d_req && (!i_if_req || (r_fair < FAIR_LIM))) w_grant_d = 1'b1;
                else if (i_if_req)                                 w_grant_i = 1'b1;
                if (w_grant_d || w_grant_i) w_next = BUSY;
            end
            BUSY: begin
                if (i_mem_ready) begin
                    w_done = 1'b1;
                    w_next = RESP;
                end else if (w_expired) begin
                    w_tmo  = 1'b1;
                    w_next = RESP;
                end
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_owner     <= OWN_I;
            r_fair      <= '0;
            o_if_ack    <= 1'b0;
            o_if_rdata  <= '0;
            o_if_err    <= 1'b0;
            o_d_ack     <= 1'b0;
            o_d_rdata   <= '0;
            o_d_err     <= 1'b0;
            o_mem_req   <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
        end else begin
            o_if_ack <= 1'b0;
            o_d_ack  <= 1'b0;
            if (w_grant_d || w_grant_i) begin
                r_owner     <= w_grant_d ? OWN_D : OWN_I;
                o_mem_req   <= 1'b1;
                o_mem_we    <= w_grant_d & i_d_we;
                o_mem_addr  <= w_grant_d ? i_d_addr : i_if_addr;
                o_mem_wdata <= w_grant_d ? i_d_wdata : '0;
                // Streak of data grants only counts while fetch is being held off
                if (w_grant_d && i_if_req) begin
                    if (r_fair != FAIR_LIM) r_fair <= r_fair + FW'(1);
                end else begin
                    r_fair <= '0;
                end
            end
            if (w_done || w_tmo) begin
                o_mem_req <= 1'b0;
                if (r_owner == OWN_D) begin
                    o_d_ack   <= 1'b1;
                    o_d_err   <= w_tmo;
                    o_d_rdata <= (w_tmo || o_mem_we) ? '0 : i_mem_rdata;
                end else begin
                    o_if_ack   <= 1'b1;
                    o_if_err   <= w_tmo;
                    o_if_rdata <= w_tmo ? '0 : i_mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench: a transaction-level model predicts grants and
// responses; a monitor compares them whenever the arbiter presents output.
module tb_mem_port_arbiter;

    localparam int FAIR_MAX = 4;
    localparam int TIMEOUT  = 8;
    localparam int NTX      = 300;
    localparam int CYC_MAX  = 50000;

    typedef struct {
        logic        owner;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } grant_t;

    typedef struct {
        logic        owner;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, d_req, d_we, mem_ready;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic        if_ack, if_err, d_ack, d_err, mem_req, mem_we;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;

    int     n_vec = 0;
    int     n_err = 0;
    int     cyc   = 0;
    logic   stop  = 1'b0;
    logic   hi_load = 1'b0;
    logic   prev_req = 1'b0;
    grant_t grant_q[$];
    resp_t  resp_q[$];

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .FAIR_MAX(FAIR_MAX), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_if_req(if_req), .i_if_addr(if_addr),
        .o_if_ack(if_ack), .o_if_rdata(if_rdata), .o_if_err(if_err),
        .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
        .o_d_ack(d_ack), .o_d_rdata(d_rdata), .o_d_err(d_err),
        .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .i_mem_ready(mem_ready), .i_mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic roll();
        return $urandom_range(0, 9) < (hi_load ? 9 : 3);
    endfunction

    // Fetch requester: holds address until acked
    initial begin
        if_req = 1'b0; if_addr = '0;
        forever begin
            @(negedge clk);
            if (stop) if_req = 1'b0;
            else if (!if_req || if_ack) begin
                if_req = 1'b0;
                if (roll()) begin
                    if_req  = 1'b1;
                    if_addr = $urandom & 32'hFFFF_FFFC;
                end
            end
        end
    end

    // Load/store requester
    initial begin
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        forever begin
            @(negedge clk);
            if (stop) d_req = 1'b0;
            else if (!d_req || d_ack) begin
                d_req = 1'b0;
                if (roll()) begin
                    d_req   = 1'b1;
                    d_we    = $urandom_range(0, 1) == 1;
                    d_addr  = $urandom & 32'hFFFF_FFFC;
                    d_wdata = $urandom;
                end
            end
        end
    end

    // Monitor
    always @(negedge clk) begin
        if (if_ack || d_ack) chk("ack_exclusive", if_ack & d_ack, 0);
        if (mem_req && !prev_req) begin
            if (grant_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL grant_unexpected: got mem_req rise at addr %0h required none", mem_addr);
            end else begin
                grant_t g;
                g = grant_q.pop_front();
                chk("grant_addr", mem_addr, g.addr);
                chk("grant_we", mem_we, g.we);
                if (g.we) chk("grant_wdata", mem_wdata, g.wdata);
            end
        end
        prev_req = mem_req;
        if (if_ack || d_ack) begin
            if (resp_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL ack_unexpected: got if_ack=%0b d_ack=%0b required none", if_ack, d_ack);
            end else begin
                resp_t r;
                r = resp_q.pop_front();
                chk("resp_owner", d_ack, r.owner);
                chk("resp_rdata", r.owner ? d_rdata : if_rdata, r.rdata);
                chk("resp_err", r.owner ? d_err : if_err, r.err);
                chk("resp_cycle", cyc, r.cyc);
            end
        end
    end

    // Reference model and memory responder
    initial begin
        int     ntx, fair, w, last, rst_at;
        logic   gd, gi, tmo, reset_hit;
        logic [31:0] rdv;
        grant_t g;
        resp_t  r;
        ntx = 0; fair = 0; rdv = '0;
        rst = 1'b1; mem_ready = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_acks", {if_ack, d_ack, if_err, d_err}, 0);
        chk("rst_mem", {mem_req, mem_we}, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_rdata", {if_rdata, d_rdata}, 0);
        rst = 1'b0;
        while (ntx < NTX && cyc < CYC_MAX) begin
            if (ntx % 40 == 0) hi_load = ~hi_load;
            mem_ready = $urandom_range(0, 3) == 0;
            mem_rdata = $urandom;
            @(posedge clk);
            gd = d_req && (!if_req || fair < FAIR_MAX);
            gi = !gd && if_req;
            if (!gd && !gi) begin
                @(negedge clk);
                continue;
            end
            ntx++;
            if (gd && if_req) fair = (fair < FAIR_MAX) ? fair + 1 : fair;
            else              fair = 0;
            g.owner = gd; g.we = gd && d_we;
            g.addr  = gd ? d_addr : if_addr; g.wdata = d_wdata;
            grant_q.push_back(g);
            tmo    = $urandom_range(0, 9) == 0;
            w      = $urandom_range(0, 3);
            last   = tmo ? TIMEOUT : w;
            rst_at = ($urandom_range(0, 9) == 0) ? $urandom_range(0, last) : -1;
            reset_hit = 1'b0;
            for (int k = 0; k <= last; k++) begin
                @(negedge clk);
                chk("mem_req_busy", mem_req, 1);
                if (k == rst_at) begin
                    rst = 1'b1; mem_ready = 1'b0;
                    @(posedge clk);
                    fair = 0;
                    @(negedge clk);
                    chk("rst_mid_mem_req", mem_req, 0);
                    chk("rst_mid_acks", {if_ack, d_ack}, 0);
                    rst = 1'b0;
                    reset_hit = 1'b1;
                    break;
                end
                mem_ready = !tmo && (k == w);
                rdv = $urandom;
                mem_rdata = rdv;
                @(posedge clk);
            end
            if (reset_hit) continue;
            r.owner = gd; r.err = tmo;
            r.rdata = (tmo || g.we) ? 32'h0 : rdv;
            r.cyc   = cyc + 1;
            resp_q.push_back(r);
            @(negedge clk);
            chk("mem_req_resp", mem_req, 0);
            mem_ready = $urandom_range(0, 1) == 1;
            mem_rdata = $urandom;
            @(posedge clk);
            @(negedge clk);
        end
        if (cyc >= CYC_MAX) begin
            n_vec++; n_err++;
            $display("FAIL cycle_budget: got %0d transactions required %0d", ntx, NTX);
        end
        rst = 1'b1; stop = 1'b1; mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("grant_q_drained", grant_q.size(), 0);
        chk("resp_q_drained", resp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
